// File: rtl/gx4000_cpr_pkg.sv
// gx4000_cpr_pkg: shared types, FOURCC constants and helpers for the CPR cartridge loader
package gx4000_cpr_pkg;
  typedef enum logic [3:0] {
    IDLE, RIFF_ID, RIFF_LEN, FORM_ID, CHUNK_ID, CHUNK_LEN, DATA, SKIP, PAD, DONE, ERR
  } state_t;
  typedef enum logic [2:0] {
    NONE = 3'd0, BAD_RIFF = 3'd1, BAD_FORM = 3'd2, CHUNK_TOO_LONG = 3'd3,
    BAD_BANK = 3'd4, TRUNCATED = 3'd5, ADDR_GAP = 3'd6
  } err_t;
  localparam logic [31:0] FOURCC_RIFF = "RIFF";
  localparam logic [31:0] FOURCC_AMS = "AMS!";
  localparam logic [15:0] FOURCC_CB = "cb";
  localparam int BANK_BYTES = 16384;
  // FOURCCs are collected first-byte-in-MSB; lengths are little-endian on the wire
  function automatic logic [31:0] le32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
  function automatic logic is_digit(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction
  function automatic logic busy_state(input state_t s);
    return !(s inside {IDLE, DONE, ERR});
  endfunction
endpackage

// File: rtl/gx4000_cpr_field_shift.sv
// gx4000_cpr_field_shift: 4-byte field collector with byte count and completion flag
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart collection (new download)
//   en, din  : accepted field byte
//   word     : collected field including the byte currently offered on din
//   cnt      : bytes already collected (0..3)
//   full     : the byte on din completes the 4-byte field this cycle
module gx4000_cpr_field_shift (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [1:0]  cnt,
  output logic        full
);
  logic [23:0] sh;
  assign word = {sh, din};
  assign full = en && cnt == 2'd3;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sh <= '0;
      cnt <= '0;
    end else if (en) begin
      sh <= word[23:0];
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/gx4000_cpr_loader.sv
// gx4000_cpr_loader: parses a CPR (RIFF "AMS!") image from the ioctl stream into SDRAM bank slots
//   clk_sys, reset            : clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout : download byte stream
//   cart_addr/data/wr         : SDRAM write port, one strobe per payload byte, 1-cycle latency
//   bank_valid, bank_count    : banks that received payload and their number
//   parse_busy/done/error, err_code : parse status
//   cpr_checksum              : payload byte sum, present only with GX4000_CPR_CHECKSUM_EN
module gx4000_cpr_loader
  import gx4000_cpr_pkg::*;
#(
  parameter logic [7:0]  CPR_INDEX = 8'h02,
  parameter logic [24:0] CART_BASE = 25'h0800000,
  parameter int          MAX_BANKS = 32
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  output logic [24:0]          cart_addr,
  output logic [7:0]           cart_data,
  output logic                 cart_wr,
  output logic [MAX_BANKS-1:0] bank_valid,
  output logic [5:0]           bank_count,
  output logic                 parse_busy,
  output logic                 parse_done,
  output logic                 parse_error,
`ifdef GX4000_CPR_CHECKSUM_EN
  output logic [15:0]          cpr_checksum,
`endif
  output logic [2:0]           err_code
);
  localparam int BW = $clog2(MAX_BANKS);
  state_t state, ns;
  err_t ec, ne;
  logic dl_q, odd, full;
  logic [24:0] exp_off;
  logic [31:0] chunk_id, rem, word, len;
  logic [BW-1:0] bank;
  logic [13:0] dptr;
  logic [1:0] cnt;
  logic [6:0] bnum;
  logic start, fall, acc, addr_ok, cb, bank_ok;
  assign start = ioctl_download && !dl_q && ioctl_index == CPR_INDEX;
  assign fall = dl_q && !ioctl_download;
  assign acc = ioctl_wr && ioctl_download && ioctl_index == CPR_INDEX && busy_state(state);
  assign addr_ok = ioctl_addr == exp_off;
  assign len = le32(word);
  assign cb = chunk_id[31:16] == FOURCC_CB;
  assign bnum = 7'(chunk_id[11:8]) * 7'd10 + 7'(chunk_id[3:0]);
  assign bank_ok = is_digit(chunk_id[15:8]) && is_digit(chunk_id[7:0]) && bnum < 7'(MAX_BANKS);
  assign err_code = ec;
  gx4000_cpr_field_shift u_field (
    .clk (clk_sys),
    .rst (reset),
    .clr (start),
    .en  (acc && addr_ok && state inside {RIFF_ID, RIFF_LEN, FORM_ID, CHUNK_ID, CHUNK_LEN}),
    .din (ioctl_dout),
    .word(word),
    .cnt (cnt),
    .full(full)
  );
  // Bytes need ioctl_download=1 and the falling edge sees it at 0, so a byte always lands before the end check
  always_comb begin
    ns = state;
    ne = ec;
    if (start) begin
      ns = RIFF_ID;
      ne = NONE;
    end else if (acc && !addr_ok) begin
      ns = ERR;
      ne = ADDR_GAP;
    end else if (acc) begin
      case (state)
        RIFF_ID:
          if (full && word != FOURCC_RIFF) begin
            ns = ERR;
            ne = BAD_RIFF;
          end else if (full) ns = RIFF_LEN;
        RIFF_LEN: if (full) ns = FORM_ID;
        FORM_ID:
          if (full && word != FOURCC_AMS) begin
            ns = ERR;
            ne = BAD_FORM;
          end else if (full) ns = CHUNK_ID;
        CHUNK_ID: if (full) ns = CHUNK_LEN;
        CHUNK_LEN:
          if (full && cb && !bank_ok) begin
            ns = ERR;
            ne = BAD_BANK;
          end else if (full && cb && len > 32'(BANK_BYTES)) begin
            ns = ERR;
            ne = CHUNK_TOO_LONG;
          end else if (full) ns = len == 32'd0 ? CHUNK_ID : cb ? DATA : SKIP;
        DATA, SKIP: if (rem == 32'd1) ns = odd ? PAD : CHUNK_ID;
        PAD: ns = CHUNK_ID;
        default: ;
      endcase
    end else if (fall && busy_state(state)) begin
      ns = state == CHUNK_ID && cnt == 2'd0 ? DONE : ERR;
      ne = state == CHUNK_ID && cnt == 2'd0 ? NONE : TRUNCATED;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      ec <= NONE;
      dl_q <= 1'b1;
      parse_busy <= 1'b0;
      parse_done <= 1'b0;
      parse_error <= 1'b0;
      cart_addr <= '0;
      cart_data <= '0;
      cart_wr <= 1'b0;
      bank_valid <= '0;
      bank_count <= '0;
      exp_off <= '0;
      chunk_id <= '0;
      rem <= '0;
      odd <= 1'b0;
      bank <= '0;
      dptr <= '0;
`ifdef GX4000_CPR_CHECKSUM_EN
      cpr_checksum <= '0;
`endif
    end else begin
      state <= ns;
      ec <= ne;
      dl_q <= ioctl_download;
      parse_busy <= busy_state(ns);
      parse_done <= ns == DONE;
      parse_error <= ns == ERR;
      cart_wr <= 1'b0;
      if (start) begin
        bank_valid <= '0;
        bank_count <= '0;
        exp_off <= '0;
`ifdef GX4000_CPR_CHECKSUM_EN
        cpr_checksum <= '0;
`endif
      end else if (acc) begin
        exp_off <= exp_off + 25'd1;
        if (addr_ok) begin
          case (state)
            CHUNK_ID: if (full) chunk_id <= word;
            CHUNK_LEN: begin
              rem <= len;
              odd <= len[0];
              bank <= bnum[BW-1:0];
              dptr <= '0;
            end
            DATA: begin
              cart_wr <= 1'b1;
              cart_data <= ioctl_dout;
              cart_addr <= CART_BASE + 25'({bank, dptr});
              dptr <= dptr + 14'd1;
              rem <= rem - 32'd1;
              if (dptr == 14'd0) begin
                bank_valid[bank] <= 1'b1;
                if (!bank_valid[bank]) bank_count <= bank_count + 6'd1;
              end
`ifdef GX4000_CPR_CHECKSUM_EN
              cpr_checksum <= cpr_checksum + 16'(ioctl_dout);
`endif
            end
            SKIP: rem <= rem - 32'd1;
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_gx4000_cpr_loader.sv
// tb_gx4000_cpr_loader: directed CPR images checked against an expected-write scoreboard and final status
module tb_gx4000_cpr_loader;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic ioctl_download = 1'b0;
  logic [7:0] ioctl_index = 8'h00;
  logic ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0;
  logic [24:0] cart_addr;
  logic [7:0] cart_data;
  logic cart_wr;
  logic [31:0] bank_valid;
  logic [5:0] bank_count;
  logic parse_busy, parse_done, parse_error;
  logic [2:0] err_code;
`ifdef GX4000_CPR_CHECKSUM_EN
  logic [15:0] cpr_checksum;
  logic [15:0] exp_ck;
`endif
  always #5 clk_sys = ~clk_sys;
  gx4000_cpr_loader dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .cart_addr(cart_addr),
    .cart_data(cart_data),
    .cart_wr(cart_wr),
    .bank_valid(bank_valid),
    .bank_count(bank_count),
    .parse_busy(parse_busy),
    .parse_done(parse_done),
    .parse_error(parse_error),
`ifdef GX4000_CPR_CHECKSUM_EN
    .cpr_checksum(cpr_checksum),
`endif
    .err_code(err_code)
  );
  int total = 0;
  int bad = 0;
  int nwr = 0;
  logic [24:0] first_a, last_a;
  logic [7:0] img[$];
  logic [24:0] ew_a[$];
  logic [7:0] ew_d[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] pat(input int i, input int s);
    return 8'(i * 7 + s * 31 + (i >> 8));
  endfunction
  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask
  task automatic put4(input logic [31:0] v);
    img.push_back(v[31:24]);
    img.push_back(v[23:16]);
    img.push_back(v[15:8]);
    img.push_back(v[7:0]);
  endtask
  task automatic putle(input logic [31:0] v);
    img.push_back(v[7:0]);
    img.push_back(v[15:8]);
    img.push_back(v[23:16]);
    img.push_back(v[31:24]);
  endtask
  task automatic new_image(input logic [31:0] riff);
    img.delete();
    ew_a.delete();
    ew_d.delete();
`ifdef GX4000_CPR_CHECKSUM_EN
    exp_ck = '0;
`endif
    put4(riff);
    putle(32'h1234);
    put4("AMS!");
  endtask
  task automatic chunk(input logic [31:0] id, input int len, input int npay, input int seed);
    put4(id);
    putle(32'(len));
    for (int i = 0; i < npay; i++) img.push_back(pat(i, seed));
    if (npay == len && len % 2 == 1) img.push_back(8'h00);
  endtask
  // Expected SDRAM writes: bank slot base plus payload offset, in stream order
  task automatic expw(input int bank, input int n, input int seed);
    for (int i = 0; i < n; i++) begin
      ew_a.push_back(25'h0800000 + 25'(bank * 16384 + i));
      ew_d.push_back(pat(i, seed));
`ifdef GX4000_CPR_CHECKSUM_EN
      exp_ck = exp_ck + 16'(pat(i, seed));
`endif
    end
  endtask
  task automatic send(input int gap_at, input int rst_at);
    nwr = 0;
    ioctl_index = 8'h02;
    ioctl_download = 1'b1;
    tick;
    chk("busy_at_start", parse_busy, 1'b1);
    for (int i = 0; i < img.size(); i++) begin
      if (i == rst_at) begin
        ioctl_wr = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("wr_during_reset", cart_wr, 1'b0);
      end
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i + ((gap_at >= 0 && i >= gap_at) ? 1 : 0));
      ioctl_dout = img[i];
      tick;
    end
    ioctl_wr = 1'b0;
    tick;
    tick;
    ioctl_download = 1'b0;
    tick;
    tick;
  endtask
  task automatic ends(input string nm, input logic d, input logic e, input logic [2:0] ec,
                      input logic [31:0] bv, input logic [5:0] bc);
    chk({nm, "_done"}, parse_done, d);
    chk({nm, "_error"}, parse_error, e);
    chk({nm, "_err_code"}, err_code, ec);
    chk({nm, "_busy"}, parse_busy, 1'b0);
    chk({nm, "_bank_valid"}, bank_valid, bv);
    chk({nm, "_bank_count"}, bank_count, bc);
    chk({nm, "_missing_writes"}, ew_a.size(), 0);
`ifdef GX4000_CPR_CHECKSUM_EN
    chk({nm, "_checksum"}, cpr_checksum, exp_ck);
`endif
  endtask
  task automatic reset_vals(input string nm);
    chk({nm, "_cart_wr"}, cart_wr, 1'b0);
    chk({nm, "_cart_addr"}, cart_addr, 25'h0);
    chk({nm, "_cart_data"}, cart_data, 8'h0);
    chk({nm, "_bank_valid"}, bank_valid, 32'h0);
    chk({nm, "_bank_count"}, bank_count, 6'h0);
    chk({nm, "_flags"}, {parse_busy, parse_done, parse_error}, 3'b000);
    chk({nm, "_err_code"}, err_code, 3'h0);
  endtask
  always @(negedge clk_sys) begin
    if (cart_wr === 1'b1) begin
      nwr++;
      if (nwr == 1) first_a = cart_addr;
      last_a = cart_addr;
      if (ew_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h want no write", cart_addr, cart_data);
      end else begin
        chk("wr_addr", cart_addr, ew_a.pop_front());
        chk("wr_data", cart_data, ew_d.pop_front());
      end
    end
  end
  initial begin
    tick;
    tick;
    reset = 1'b0;
    tick;
    reset_vals("reset");
    // Valid two-bank image, odd second bank with pad byte
    new_image("RIFF");
    chunk("cb00", 16384, 16384, 1);
    chunk("cb01", 3, 3, 2);
    expw(0, 16384, 1);
    expw(1, 3, 2);
    send(-1, -1);
    ends("valid", 1'b1, 1'b0, 3'd0, 32'h3, 6'd2);
    chk("valid_nwr", nwr, 16387);
    chk("valid_last_addr", last_a, 25'h0804002);
    // Unknown chunk skipped, empty bank chunk ignored
    new_image("RIFF");
    chunk("fmt ", 5, 5, 3);
    chunk("cb07", 0, 0, 0);
    chunk("cb02", 2, 2, 4);
    expw(2, 2, 4);
    send(-1, -1);
    ends("skip", 1'b1, 1'b0, 3'd0, 32'h4, 6'd1);
    chk("skip_first_addr", first_a, 25'h0808000);
    chk("skip_nwr", nwr, 2);
    new_image("RIFX");
    chunk("cb00", 4, 4, 1);
    send(-1, -1);
    ends("bad_riff", 1'b0, 1'b1, 3'd1, 32'h0, 6'd0);
    chk("bad_riff_nwr", nwr, 0);
    new_image("RIFF");
    chunk("cb40", 4, 4, 1);
    send(-1, -1);
    ends("bad_bank", 1'b0, 1'b1, 3'd4, 32'h0, 6'd0);
    new_image("RIFF");
    chunk("cb03", 16385, 10, 1);
    send(-1, -1);
    ends("too_long", 1'b0, 1'b1, 3'd3, 32'h0, 6'd0);
    new_image("RIFF");
    chunk("cb05", 1000, 100, 2);
    expw(5, 100, 2);
    send(-1, -1);
    ends("truncated", 1'b0, 1'b1, 3'd5, 32'h20, 6'd1);
    chk("truncated_nwr", nwr, 100);
    new_image("RIFF");
    chunk("cb00", 16384, 16384, 6);
    chunk("cb01", 3, 3, 7);
    expw(0, 16384, 6);
    expw(1, 3, 7);
    send(-1, -1);
    ends("recover", 1'b1, 1'b0, 3'd0, 32'h3, 6'd2);
    new_image("RIFF");
    chunk("cb00", 4, 4, 5);
    chunk("cb00", 4, 4, 9);
    expw(0, 4, 5);
    expw(0, 4, 9);
    send(-1, -1);
    ends("duplicate", 1'b1, 1'b0, 3'd0, 32'h1, 6'd1);
    new_image("RIFF");
    chunk("cb01", 8, 8, 3);
    expw(1, 4, 3);
    send(24, -1);
    ends("addr_gap", 1'b0, 1'b1, 3'd6, 32'h2, 6'd1);
    // Reset mid-DATA: writes stop and the rest of the download is ignored
    new_image("RIFF");
    chunk("cb02", 64, 64, 8);
    expw(2, 10, 8);
    send(-1, 30);
    reset_vals("mid_reset");
    chk("mid_reset_nwr", nwr, 10);
    chk("mid_reset_missing_writes", ew_a.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
